// File: rtl/calc_pkg.sv
// calc_pkg: widths, timeout defaults and FSM encoding shared by the calc requester, compute unit and benches.
package calc_pkg;
    localparam int A_W_DEF = 8;
    localparam int B_W_DEF = 8;
    localparam int Y_W_DEF = 24;
    localparam int ACK_TO_DEF = 15;
    localparam int DONE_TO_DEF = 255;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;
    function automatic int max_int(input int x, input int y);
        return x > y ? x : y;
    endfunction
endpackage

// File: rtl/calc_timeout_cnt.sv
// calc_timeout_cnt: free-running cycle counter with synchronous clear and terminal-count flag.
module calc_timeout_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk_i) begin
        if (!rst_i || clr) cnt <= '0;
        else cnt <= cnt + W'(1);
    end
    // tc flags the cycle that completes limit cycles in the current state
    always_comb tc = cnt == limit - W'(1);
endmodule

// File: rtl/calc_requester.sv
// calc_requester: drives the cube-plus-sqrt unit's start/busy handshake with timeouts and returns results.
module calc_requester
    import calc_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int Y_W = Y_W_DEF,
    parameter int ACK_TO = ACK_TO_DEF,
    parameter int DONE_TO = DONE_TO_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [A_W-1:0]   req_a_bi,
    input  logic [B_W-1:0]   req_b_bi,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Y_W-1:0]   rsp_y_bo,
    output logic             rsp_err_o,
    output logic             calc_start_o,
    output logic [A_W-1:0]   calc_a_bo,
    output logic [B_W-1:0]   calc_b_bo,
    input  logic             calc_busy_i,
    input  logic [Y_W-1:0]   calc_y_bi,
    output logic [CNT_W-1:0] done_cnt_bo,
    output logic             idle_o
);
    localparam int TO_W = $clog2(max_int(ACK_TO, DONE_TO) + 1);
    state_t state;
    logic leave, clr, tc;
    logic [TO_W-1:0] limit;
    always_comb begin
        leave = state == ISSUE ? (calc_busy_i || tc) : state == RUN ? (!calc_busy_i || tc) : 1'b0;
        clr = !(state == ISSUE || state == RUN) || leave;
        limit = state == ISSUE ? TO_W'(ACK_TO) : TO_W'(DONE_TO);
    end
    calc_timeout_cnt #(.W(TO_W)) u_to (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr(clr),
        .limit(limit),
        .tc(tc)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            req_ready_o <= 1'b1;
            idle_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_y_bo <= '0;
            rsp_err_o <= 1'b0;
            calc_start_o <= 1'b0;
            calc_a_bo <= '0;
            calc_b_bo <= '0;
            done_cnt_bo <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i && req_ready_o) begin
                    calc_a_bo <= req_a_bi;
                    calc_b_bo <= req_b_bi;
                    calc_start_o <= 1'b1;
                    req_ready_o <= 1'b0;
                    idle_o <= 1'b0;
                    state <= ISSUE;
                end
                ISSUE: if (calc_busy_i) begin
                    calc_start_o <= 1'b0;
                    state <= RUN;
                end else if (tc) begin
                    calc_start_o <= 1'b0;
                    rsp_err_o <= 1'b1;
                    rsp_y_bo <= '0;
                    rsp_valid_o <= 1'b1;
                    state <= RESP;
                end
                RUN: if (!calc_busy_i || tc) begin
                    rsp_err_o <= calc_busy_i;
                    rsp_y_bo <= calc_busy_i ? '0 : calc_y_bi;
                    rsp_valid_o <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    done_cnt_bo <= done_cnt_bo + CNT_W'(1);
                    req_ready_o <= 1'b1;
                    idle_o <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_requester.sv
// tb_calc_requester: randomized self-checking bench with a behavioural compute-unit model and result reference.
module tb_calc_requester;
    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic req_valid_i = 1'b0, req_ready_o;
    logic [7:0] req_a_bi = '0, req_b_bi = '0;
    logic rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
    logic [23:0] rsp_y_bo;
    logic calc_start_o;
    logic [7:0] calc_a_bo, calc_b_bo;
    logic calc_busy_i = 1'b0;
    logic [23:0] calc_y_bi = '0;
    logic [15:0] done_cnt_bo;
    logic idle_o;
    int n_tests = 0, n_fail = 0;
    logic [15:0] exp_cnt = '0;
    int um = 0, un = 4, ph = 0, uc = 0;

    always #5 clk = ~clk;

    calc_requester dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_bi(req_a_bi), .req_b_bi(req_b_bi),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_y_bo(rsp_y_bo), .rsp_err_o(rsp_err_o),
        .calc_start_o(calc_start_o), .calc_a_bo(calc_a_bo), .calc_b_bo(calc_b_bo),
        .calc_busy_i(calc_busy_i), .calc_y_bi(calc_y_bi),
        .done_cnt_bo(done_cnt_bo), .idle_o(idle_o)
    );

    function automatic logic [23:0] ref_y(input int a, input int b);
        int r = 0;
        while ((r + 1) * (r + 1) <= b) r++;
        return 24'(a * a * a + r);
    endfunction

    // unit model: mode 0 raises busy one cycle after seeing start for un cycles, 1 never busy, 2 stuck busy
    always @(posedge clk) begin
        if (!rst_i || um == 1) begin
            calc_busy_i <= 1'b0;
            ph <= 0;
        end else if (um == 2) calc_busy_i <= 1'b1;
        else if (ph == 0) begin
            calc_busy_i <= 1'b0;
            if (calc_start_o) ph <= 1;
        end else if (ph == 1) begin
            calc_busy_i <= 1'b1;
            uc <= un;
            ph <= 2;
        end else if (uc == 1) begin
            calc_busy_i <= 1'b0;
            calc_y_bi <= ref_y(int'(calc_a_bo), int'(calc_b_bo));
            ph <= 0;
        end else uc <= uc - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input int mode, input int n, input int hold,
                       input logic [23:0] ey, input logic ee, input int elat, input int estart);
        int cyc = 0, st = 0;
        logic ok = 1'b1;
        logic [23:0] y0;
        um = mode;
        un = n;
        @(negedge clk);
        check("idle", 32'(idle_o), 1);
        check("req_ready", 32'(req_ready_o), 1);
        req_valid_i = 1'b1;
        req_a_bi = a;
        req_b_bi = b;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_a_bi = 8'($urandom);
        req_b_bi = 8'($urandom);
        check("ready_low", 32'(req_ready_o), 0);
        while (!rsp_valid_o && cyc < 600) begin
            if (calc_start_o) st++;
            if (calc_a_bo !== a || calc_b_bo !== b || req_ready_o) ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(elat));
        if (estart >= 0) check("start_cycles", 32'(st), 32'(estart));
        check("operands_held", 32'(ok), 1);
        check("y", 32'(rsp_y_bo), 32'(ey));
        check("err", 32'(rsp_err_o), 32'(ee));
        y0 = rsp_y_bo;
        ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_y_bo !== y0 || rsp_err_o !== ee) ok = 1'b0;
        end
        if (hold > 0) check("rsp_hold", 32'(ok), 1);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        exp_cnt++;
        check("valid_drop", 32'(rsp_valid_o), 0);
        check("done_cnt", 32'(done_cnt_bo), 32'(exp_cnt));
    endtask

    initial begin
        logic [7:0] pa [3] = '{8'd1, 8'd3, 8'd10};
        logic [7:0] pb [3] = '{8'd1, 8'd16, 8'd100};
        logic [23:0] py [3] = '{24'd2, 24'd31, 24'd1010};
        logic ok;
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready_o), 1);
        check("rst_idle", 32'(idle_o), 1);
        check("rst_valid", 32'(rsp_valid_o), 0);
        check("rst_start", 32'(calc_start_o), 0);
        check("rst_cnt", 32'(done_cnt_bo), 0);
        check("rst_y", 32'(rsp_y_bo), 0);
        rst_i = 1'b1;
        txn(8'd2, 8'd9, 0, 4, 0, 24'd11, 1'b0, 7, 3);
        txn(8'd255, 8'd255, 0, 4, 2, 24'd16581390, 1'b0, 7, 3);
        txn(8'd7, 8'd50, 1, 4, 0, 24'd0, 1'b1, 15, 15);
        txn(8'd5, 8'd5, 2, 4, 10, 24'd0, 1'b1, 256, 1);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a, b;
            int n, h;
            a = 8'($urandom);
            b = 8'($urandom);
            n = int'($urandom_range(1, 6));
            h = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) txn(a, b, 1, n, h, 24'd0, 1'b1, 15, 15);
            else txn(a, b, 0, n, h, ref_y(int'(a), int'(b)), 1'b0, n + 3, 3);
        end
        um = 0;
        un = 4;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a_bi = pa[i];
            req_b_bi = pb[i];
            cyc = 0;
            while (!req_ready_o && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check("cont_ready_wait", 32'(req_ready_o), 1);
            @(negedge clk);
            ok = 1'b1;
            cyc = 0;
            while (!rsp_valid_o && cyc < 50) begin
                if (req_ready_o) ok = 1'b0;
                @(negedge clk);
                cyc++;
            end
            check("cont_ready_low", 32'(ok), 1);
            check("cont_y", 32'(rsp_y_bo), 32'(py[i]));
            exp_cnt++;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        check("cont_cnt", 32'(done_cnt_bo), 32'(exp_cnt));
        un = 20;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_a_bi = 8'd4;
        req_b_bi = 8'd4;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (6) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        exp_cnt = '0;
        check("mid_rst_idle", 32'(idle_o), 1);
        check("mid_rst_start", 32'(calc_start_o), 0);
        check("mid_rst_valid", 32'(rsp_valid_o), 0);
        check("mid_rst_cnt", 32'(done_cnt_bo), 0);
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid_o) ok = 1'b0;
        end
        check("no_stale_rsp", 32'(ok), 1);
        txn(8'd3, 8'd200, 0, 2, 0, ref_y(3, 200), 1'b0, 5, 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_requester.md
Name: calc_requester

Overview:
- Initiator for the cube-plus-square-root compute unit, computing y = a^3 + floor(sqrt(b)).
- Accepts operand pairs from an upstream valid/ready stream.
- Drives the unit's start/busy handshake and holds operands stable until the unit acknowledges.
- Captures y when busy falls and returns it on a downstream valid/ready stream; adds timeout detection and a completion counter.

Parameters:
- A_W, 8, operand a width
- B_W, 8, operand b width
- Y_W, 24, result width
- ACK_TO, 15, max cycles from start to busy rising
- DONE_TO, 255, max cycles busy may stay high
- CNT_W, 16, completion counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- req_valid_i  in  1  upstream operand pair valid
- req_ready_o  out  1  block can accept a pair
- req_a_bi  in  A_W  operand a
- req_b_bi  in  B_W  operand b
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  downstream accepts result
- rsp_y_bo  out  Y_W  captured result
- rsp_err_o  out  1  result is a timeout, y forced to 0
- calc_start_o  out  1  start to compute unit
- calc_a_bo  out  A_W  operand a to unit
- calc_b_bo  out  B_W  operand b to unit
- calc_busy_i  in  1  unit busy
- calc_y_bi  in  Y_W  unit result
- done_cnt_bo  out  CNT_W  completed transactions, errors included, wraps
- idle_o  out  1  FSM in IDLE

Behaviour:
- Reset (rst_i==0 at a clk edge): state IDLE; all outputs 0 except req_ready_o=1 and idle_o=1.
  - Reset overrides any in-flight transaction; the pending result is discarded.
  - Upon leaving reset, calc_start_o is already 0; the unit's own reset is separate.
- States: IDLE, ISSUE, RUN, RESP. All outputs are registered.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o: latch a,b into calc_a_bo/calc_b_bo, set calc_start_o=1, go to ISSUE.
- ISSUE:
  - Hold calc_start_o=1 and operands; count cycles.
  - If calc_busy_i==1: drop calc_start_o next cycle, go to RUN.
  - If the count reaches ACK_TO with no busy: drop start, rsp_err_o=1, rsp_y_bo=0, go to RESP.
  - A busy already high on entry to ISSUE (stale) counts as the ack.
- RUN:
  - Operands are held until the transaction ends.
  - If calc_busy_i==0: capture calc_y_bi into rsp_y_bo, rsp_err_o=0, go to RESP.
  - Capture uses the value present in the same cycle busy is seen low.
  - If busy stays high DONE_TO cycles: rsp_err_o=1, rsp_y_bo=0, go to RESP.
- RESP:
  - rsp_valid_o=1; rsp_y_bo and rsp_err_o stable until accepted.
  - On rsp_ready_i: rsp_valid_o=0, done_cnt_bo+1 (mod 2^CNT_W), go to IDLE.
- Latency, ideal unit (busy rises 1 cycle after start, holds N cycles): accept edge -> rsp_valid_o high after N+3 cycles.
- Throughput: one transaction in flight. req_ready_o=0 outside IDLE.
  - No skid buffer; no back-to-back accept in the RESP->IDLE cycle (ready is registered).
- The timeout counter is shared by ISSUE and RUN, cleared on every state change, width clog2(max(ACK_TO,DONE_TO)+1).
- Widths are passed through unmodified; no arithmetic is performed on y.

Decomposition:
- Package calc_pkg: A_W/B_W/Y_W defaults, state enum encoding (IDLE=0, ISSUE=1, RUN=2, RESP=3), timeout defaults.
- Shared with the compute unit and its bench.
- One natural sub-module: calc_timeout_cnt (load/clear, terminal-count flag), instantiated once.
- FSM and datapath registers stay in calc_requester.

Test Plan:
- Reset release, then req a=2,b=9 with model unit (busy 1 cycle after start, 4 cycles) -> rsp_y_bo=11, rsp_err_o=0, rsp_valid_o 7 cycles after accept, done_cnt_bo=1.
- a=255,b=255 -> rsp_y_bo=16581390; calc_a_bo/calc_b_bo stable from ISSUE through RUN.
- Unit never raises busy, ACK_TO=15 -> start high 15 cycles then low, rsp_err_o=1, rsp_y_bo=0, counter still increments.
- Busy stuck high, DONE_TO=255 -> error response after 255 RUN cycles; hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o/rsp_y_bo held unchanged.
- req_valid_i asserted continuously, 3 pairs (1,1),(3,16),(10,100) -> results 2,31,1010 in order; req_ready_o low from each accept until IDLE.
- rst_i=0 asserted mid-RUN -> next edge: state IDLE, calc_start_o=0, rsp_valid_o=0, done_cnt_bo=0; no stale response afterwards.
